// File: rtl/tcam_search_engine.sv
// Ternary CAM search engine: 2**CAM_AW entries with per-entry data, care
// mask and valid bit. Searches compare against every entry in parallel under
// a per-search global mask. Results (lowest matching index, hit, multi-hit,
// hit count) leave through a two-stage pipeline with valid/ready backpressure.
module tcam_search_engine #(
  parameter int CAM_DW = 32,
  parameter int CAM_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_install,
  input  logic [CAM_AW-1:0] wr_addr,
  input  logic [CAM_DW-1:0] wr_data,
  input  logic [CAM_DW-1:0] wr_mask,
  input  logic              flush,
  input  logic              srch_valid,
  output logic              srch_ready,
  input  logic [CAM_DW-1:0] srch_key,
  input  logic [CAM_DW-1:0] srch_gmask,
  output logic              rslt_valid,
  input  logic              rslt_ready,
  output logic              rslt_hit,
  output logic [CAM_AW-1:0] rslt_addr,
  output logic              rslt_multi,
  output logic [CAM_AW:0]   rslt_count,
  output logic [CAM_AW:0]   entry_count
);

  localparam int unsigned DEPTH = 1 << CAM_AW;
  localparam logic [CAM_AW:0] CNT_ONE = {{CAM_AW{1'b0}}, 1'b1};

  logic [CAM_DW-1:0] tbl_data [DEPTH];
  logic [CAM_DW-1:0] tbl_mask [DEPTH];
  logic [DEPTH-1:0]  tbl_valid;
  logic [CAM_AW:0]   cnt_q;

  logic              stall;
  logic              accept;
  logic [DEPTH-1:0]  match_vec;

  logic              s1_full;
  logic [DEPTH-1:0]  s1_vec;

  logic              enc_hit;
  logic              enc_found;
  logic [CAM_AW-1:0] enc_addr;
  logic [CAM_AW:0]   enc_count;

  // Table updates take the whole cycle, so searches are refused alongside
  // them; a full S1 behind a stalled S2 also refuses new work.
  assign stall       = rslt_valid & ~rslt_ready;
  assign srch_ready  = rst_n & ~wr_en & ~flush & ~(stall & s1_full);
  assign accept      = srch_valid & srch_ready;
  assign entry_count = cnt_q;

  // Parallel ternary compare of the key against every entry.
  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_vec[i] = tbl_valid[i] &
                     (((srch_key ^ tbl_data[i]) & tbl_mask[i] & srch_gmask) == '0);
    end
  end

  // Lowest-index priority encode and popcount of the captured match vector.
  always_comb begin
    enc_hit   = |s1_vec;
    enc_found = 1'b0;
    enc_addr  = '0;
    enc_count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (s1_vec[i] && !enc_found) begin
        enc_addr  = CAM_AW'(i);
        enc_found = 1'b1;
      end
      enc_count = enc_count + {{CAM_AW{1'b0}}, s1_vec[i]};
    end
  end

  // Table storage and occupancy count; flush overrides a coincident write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_data[i] <= '0;
        tbl_mask[i] <= '0;
      end
      tbl_valid <= '0;
      cnt_q     <= '0;
    end else if (flush) begin
      tbl_valid <= '0;
      cnt_q     <= '0;
    end else if (wr_en) begin
      if (wr_install) begin
        tbl_data[wr_addr]  <= wr_data;
        tbl_mask[wr_addr]  <= wr_mask;
        tbl_valid[wr_addr] <= 1'b1;
        if (!tbl_valid[wr_addr]) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else if (tbl_valid[wr_addr]) begin
        tbl_valid[wr_addr] <= 1'b0;
        cnt_q              <= cnt_q - CNT_ONE;
      end
    end
  end

  // Two-stage result pipeline; S1 may still refill while S2 is stalled as
  // long as S1 itself is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full    <= 1'b0;
      s1_vec     <= '0;
      rslt_valid <= 1'b0;
      rslt_hit   <= 1'b0;
      rslt_addr  <= '0;
      rslt_multi <= 1'b0;
      rslt_count <= '0;
    end else begin
      if (!stall) begin
        rslt_valid <= s1_full;
        if (s1_full) begin
          rslt_hit   <= enc_hit;
          rslt_addr  <= enc_addr;
          rslt_multi <= (enc_count > CNT_ONE);
          rslt_count <= enc_count;
        end
      end
      if (!stall || !s1_full) begin
        s1_full <= accept;
        if (accept) begin
          s1_vec <= match_vec;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcam_search_engine.sv
// Directed bench for tcam_search_engine with a table-level reference model
// and a per-cycle compare process.
module tb_tcam_search_engine;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] addr;
    logic          multi;
    logic [AW:0]   count;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          wr_install;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          flush;
  logic          srch_valid;
  logic          srch_ready;
  logic [DW-1:0] srch_key;
  logic [DW-1:0] srch_gmask;
  logic          rslt_valid;
  logic          rslt_ready;
  logic          rslt_hit;
  logic [AW-1:0] rslt_addr;
  logic          rslt_multi;
  logic [AW:0]   rslt_count;
  logic [AW:0]   entry_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 0;

  logic [DW-1:0] m_data  [DEPTH];
  logic [DW-1:0] m_mask  [DEPTH];
  bit            m_valid [DEPTH];
  res_t          exp_q[$];

  tcam_search_engine #(.CAM_DW(DW), .CAM_AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_install  (wr_install),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .flush       (flush),
    .srch_valid  (srch_valid),
    .srch_ready  (srch_ready),
    .srch_key    (srch_key),
    .srch_gmask  (srch_gmask),
    .rslt_valid  (rslt_valid),
    .rslt_ready  (rslt_ready),
    .rslt_hit    (rslt_hit),
    .rslt_addr   (rslt_addr),
    .rslt_multi  (rslt_multi),
    .rslt_count  (rslt_count),
    .entry_count (entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic res_t model_search(input logic [DW-1:0] key, input logic [DW-1:0] gm);
    res_t r;
    int   n = 0;
    int   first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && (((key ^ m_data[i]) & m_mask[i] & gm) == 0)) begin
        n++;
        if (first < 0) first = i;
      end
    end
    r.hit   = (n > 0);
    r.addr  = (first < 0) ? 4'd0 : 4'(first);
    r.multi = (n > 1);
    r.count = 5'(n);
    return r;
  endfunction

  function automatic int model_entries();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  // Reference model: searches see the table as it was before this edge's update.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0; m_mask[i] = '0; m_valid[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        exp_q.delete();
      end else begin
        if (rslt_valid && rslt_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (srch_valid && srch_ready) exp_q.push_back(model_search(srch_key, srch_gmask));
        if (flush) begin
          for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else if (wr_en) begin
          if (wr_install) begin
            m_data[wr_addr]  = wr_data;
            m_mask[wr_addr]  = wr_mask;
            m_valid[wr_addr] = 1;
          end else begin
            m_valid[wr_addr] = 0;
          end
        end
      end
    end
  end

  // Compare process: occupancy every cycle, result fields whenever valid.
  initial begin
    forever begin
      @(negedge clk);
      if (started && rst_n) begin
        chk("entry_count_model", entry_count, 64'(model_entries()));
        if (rslt_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rslt_valid", rslt_valid, 0);
          end else begin
            chk("rslt_vs_model", {rslt_hit, rslt_addr, rslt_multi, rslt_count}, exp_q[0]);
          end
        end
      end
    end
  end

  task automatic do_write(input logic inst, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    wr_en = 1; wr_install = inst; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    chk("write_blocks_search", srch_ready, 0);
    @(posedge clk); #1;
    wr_en = 0; wr_install = 0;
  endtask

  task automatic search(input logic [DW-1:0] k, input logic [DW-1:0] g);
    bit ok = 0;
    srch_valid = 1; srch_key = k; srch_gmask = g;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (srch_ready) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      chk("search_accept_timeout", 0, 1);
    end
    srch_valid = 0;
  endtask

  task automatic wait_result(input string name, input res_t exp);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rslt_valid) begin ok = 1; break; end
    end
    if (ok) begin
      chk(name, {rslt_hit, rslt_addr, rslt_multi, rslt_count}, exp);
      @(posedge clk); #1;
    end else begin
      chk({name, "_timeout"}, 0, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; wr_en = 0; wr_install = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    flush = 0; srch_valid = 0; srch_key = '0; srch_gmask = '0; rslt_ready = 1;
    #2;
    chk("rst_srch_ready", srch_ready, 0);
    chk("rst_rslt_valid", rslt_valid, 0);
    chk("rst_rslt_fields", {rslt_hit, rslt_addr, rslt_multi, rslt_count}, 0);
    chk("rst_entry_count", entry_count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    started = 1;

    // Single exact-match entry; result appears in the second cycle after accept.
    do_write(1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    search(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t1_latency_not_yet", rslt_valid, 0);
    @(negedge clk);
    chk("t1_latency_valid", rslt_valid, 1);
    chk("t1_result", {rslt_hit, rslt_addr, rslt_multi, rslt_count}, {1'b1, 4'd1, 1'b0, 5'd1});
    chk("t1_entry_count", entry_count, 1);
    @(posedge clk); #1;

    // Two matches; lowest index wins.
    do_write(1, 4'd3, 32'h1234_5678, 32'hFFFF_0000);
    do_write(1, 4'd7, 32'h1234_0000, 32'hFFFF_FFFF);
    search(32'h1234_0000, 32'hFFFF_FFFF);
    wait_result("t2_multi", {1'b1, 4'd3, 1'b1, 5'd2});
    chk("t2_entry_count", entry_count, 3);

    // Global mask narrows, then removes, the compare.
    search(32'h1234_ABCD, 32'h0000_FFFF);
    wait_result("t3_gmask_low", {1'b1, 4'd3, 1'b0, 5'd1});
    search(32'h1234_ABCD, 32'h0000_0000);
    wait_result("t3_gmask_zero", {1'b1, 4'd1, 1'b1, 5'd3});

    // Backpressure: two searches fill the pipe, the third waits.
    rslt_ready = 0;
    srch_valid = 1; srch_key = 32'hFFFF_FFFF; srch_gmask = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t4_ready_first", srch_ready, 1);
    @(posedge clk); #1;
    srch_key = 32'h1234_0000;
    @(negedge clk);
    chk("t4_ready_second", srch_ready, 1);
    @(posedge clk); #1;
    srch_key = 32'h0000_0000; srch_gmask = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_ready_blocked", srch_ready, 0);
      chk("t4_held_result", {rslt_valid, rslt_hit, rslt_addr, rslt_multi, rslt_count},
          {1'b1, 1'b1, 4'd1, 1'b0, 5'd1});
    end
    @(posedge clk); #1;
    rslt_ready = 1;
    search(32'h0000_0000, 32'h0000_0000);
    wait_result("t4_second_out", {1'b1, 4'd3, 1'b1, 5'd2});
    wait_result("t4_third_out", {1'b1, 4'd1, 1'b1, 5'd3});

    // Invalidate right after accept: in-flight search keeps its captured hit.
    search(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_write(0, 4'd1, '0, '0);
    wait_result("t5_inflight_hit", {1'b1, 4'd1, 1'b0, 5'd1});
    chk("t5_entry_count", entry_count, 2);
    search(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("t5_after_miss", {1'b0, 4'd0, 1'b0, 5'd0});
    do_write(0, 4'd1, '0, '0);
    @(negedge clk);
    chk("t5_invalidate_invalid_noop", entry_count, 2);
    do_write(1, 4'd3, 32'h1234_5678, 32'hFFFF_0000);
    @(negedge clk);
    chk("t5_overwrite_keeps_count", entry_count, 2);

    // Flush wins over a coincident install.
    flush = 1; wr_en = 1; wr_install = 1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_mask = '1;
    @(negedge clk);
    chk("t6_flush_blocks_search", srch_ready, 0);
    @(posedge clk); #1;
    flush = 0; wr_en = 0; wr_install = 0;
    @(negedge clk);
    chk("t6_entry_count", entry_count, 0);
    search(32'hABCD_0123, 32'h0000_0000);
    wait_result("t6_flush_miss", {1'b0, 4'd0, 1'b0, 5'd0});

    // Full table: count reaches 2**AW, top index reachable.
    for (int i = 0; i < DEPTH; i++) do_write(1, 4'(i), 32'(i), 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t7_full_entry_count", entry_count, 16);
    search(32'h0, 32'h0);
    wait_result("t7_all_match", {1'b1, 4'd0, 1'b1, 5'd16});
    search(32'd15, 32'hFFFF_FFFF);
    wait_result("t7_top_index", {1'b1, 4'd15, 1'b0, 5'd1});
    do_write(0, 4'd15, '0, '0);
    search(32'd15, 32'hFFFF_FFFF);
    wait_result("t7_top_removed", {1'b0, 4'd0, 1'b0, 5'd0});
    chk("t7_entry_count", entry_count, 15);

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
